// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants, types and helper functions for the PWM output controller.
//   PWM_STEPS            : count steps per PWM period (8-bit counter)
//   DUTY_FULL            : duty code that forces a constant-high output
//   PWM_PRESCALE_DEFAULT : default clk cycles per PWM count step
//   NUM_OUTPUTS          : number of chip outputs driven
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int         PWM_STEPS            = 256;
   localparam logic [7:0] DUTY_FULL            = 8'hFF;
   localparam int         PWM_PRESCALE_DEFAULT = 13;
   localparam int         NUM_OUTPUTS          = 16;
   localparam int         CNT_W                = $clog2(PWM_STEPS);

   typedef logic [NUM_OUTPUTS-1:0] out_vec_t;
   typedef logic [CNT_W-1:0]       pwm_cnt_t;

   // Drive mode of a single output pin, decoded from its two enable bits.
   typedef enum logic [1:0] {
      MODE_LOW  = 2'd0,
      MODE_HIGH = 2'd1,
      MODE_PWM  = 2'd2
   } out_mode_e;

   // Output enable dominates; PWM select only matters for enabled pins.
   function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
      if (!en_out) begin
         return MODE_LOW;
      end
      return en_pwm ? MODE_PWM : MODE_HIGH;
   endfunction

   // Compare-based waveform. DUTY_FULL is special-cased so that the top code
   // gives a true 100 % output instead of 255/256.
   function automatic logic pwm_level(input pwm_cnt_t cnt, input logic [7:0] duty);
      if (duty == DUTY_FULL) begin
         return 1'b1;
      end
      return (cnt < duty);
   endfunction

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Free-running divider that produces one PWM count step every PRESCALE clk
// cycles. Counts 0..PRESCALE-1 and wraps.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   tick     out : high in the last cycle of each step (pre == PRESCALE-1)
//   pre_zero out : high in the first cycle of each step (pre == 0)
// With PRESCALE = 1 the counter stays at 0, so tick and pre_zero are both
// constantly high.
// -----------------------------------------------------------------------------
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PWM_PRESCALE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic pre_zero
);

   localparam int unsigned        PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here a default at the top), otherwise synthesis infers a latch.
   always_comb begin
      pre_d = pre_q + 1'b1;
      if (pre_q == PRE_MAX) begin
         pre_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick     = (pre_q == PRE_MAX);
   assign pre_zero = (pre_q == '0);

endmodule : pwm_prescaler

// File: rtl/pwm_output_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_output_ctrl
// Drives the 16 chip outputs as static-low, static-high or a common PWM
// waveform, from the configuration registers of the SPI register block
// (same clk domain, no synchronisers). The duty cycle is shadowed and only
// taken at a period boundary so the waveform never glitches; enables apply
// on the next clk edge.
//   clk             in  [1]  : system clock
//   rst_n           in  [1]  : asynchronous active-low reset
//   en_reg_out_7_0  in  [8]  : output enable, bits 7:0
//   en_reg_out_15_8 in  [8]  : output enable, bits 15:8
//   en_reg_pwm_7_0  in  [8]  : PWM mode select, bits 7:0
//   en_reg_pwm_15_8 in  [8]  : PWM mode select, bits 15:8
//   pwm_duty_cycle  in  [8]  : duty request, 0x00 = 0 %, 0xFF = 100 %
//   out             out [16] : registered chip outputs
//   period_start    out [1]  : one-cycle pulse on the first out cycle of a period
// Period = 256 * PRESCALE clk cycles.
// -----------------------------------------------------------------------------
module pwm_output_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PWM_PRESCALE_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             en_reg_out_7_0,
   input  logic [7:0]             en_reg_out_15_8,
   input  logic [7:0]             en_reg_pwm_7_0,
   input  logic [7:0]             en_reg_pwm_15_8,
   input  logic [7:0]             pwm_duty_cycle,
   output logic [NUM_OUTPUTS-1:0] out,
   output logic                   period_start
);

   out_vec_t   en_out;
   out_vec_t   en_pwm;

   logic       tick;
   logic       pre_zero;
   logic       bnd;
   logic       pwm_raw;
   logic [7:0] duty_eff;

   pwm_cnt_t   cnt_q;
   pwm_cnt_t   cnt_d;
   logic [7:0] duty_sh_q;
   logic [7:0] duty_sh_d;
   out_vec_t   out_q;
   out_vec_t   out_d;
   logic       period_start_q;
   logic       period_start_d;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .pre_zero (pre_zero)
   );

   always_comb begin
      // First cycle of a period: both counters at zero.
      bnd = (cnt_q == '0) && pre_zero;

      // 8-bit counter wraps 255 -> 0 on its own.
      cnt_d = tick ? cnt_q + 1'b1 : cnt_q;

      // The boundary cycle already uses the new duty, so the first output
      // cycle of a period reflects the value captured in that same cycle.
      duty_sh_d = bnd ? pwm_duty_cycle : duty_sh_q;
      duty_eff  = duty_sh_d;
      pwm_raw   = pwm_level(cnt_q, duty_eff);

      period_start_d = bnd;

      out_d = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         unique case (out_mode(en_out[i], en_pwm[i]))
            MODE_LOW:  out_d[i] = 1'b0;
            MODE_HIGH: out_d[i] = 1'b1;
            MODE_PWM:  out_d[i] = pwm_raw;
            default:   out_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         duty_sh_q      <= '0;
         out_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         duty_sh_q      <= duty_sh_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule : pwm_output_ctrl

// File: tb/tb_pwm_output_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_output_ctrl
// Self-checking bench for pwm_output_ctrl with PRESCALE = 13. A reference
// model derives the expected outputs from the number of clk edges since reset
// release (position in period = k mod 3328, count step = position / 13) and
// compares every cycle; directed scenarios additionally measure period length
// and high time.
// -----------------------------------------------------------------------------
module tb_pwm_output_ctrl;
   import pwm_pkg::*;

   localparam int P      = 13;
   localparam int PERIOD = PWM_STEPS * P;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  eo_lo = 8'h00;
   logic [7:0]  eo_hi = 8'h00;
   logic [7:0]  ep_lo = 8'h00;
   logic [7:0]  ep_hi = 8'h00;
   logic [7:0]  duty  = 8'h00;
   logic [15:0] out;
   logic        period_start;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_output_ctrl #(
      .PRESCALE (P)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (eo_lo),
      .en_reg_out_15_8 (eo_hi),
      .en_reg_pwm_7_0  (ep_lo),
      .en_reg_pwm_15_8 (ep_hi),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned k         = 0;     // clk edges since reset release
   logic [7:0]  m_duty_sh = 8'h00;
   logic [15:0] exp_out   = 16'h0000;
   logic        exp_ps    = 1'b0;

   function automatic logic [15:0] model_out(input int unsigned kk, input logic [7:0] d,
                                             input logic [15:0] eo, input logic [15:0] ep);
      int unsigned step;
      logic        high;
      step = (kk % PERIOD) / P;
      high = (d == 8'hFF) || (step < d);
      return eo & (~ep | {16{high}});
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= 0;
         m_duty_sh <= 8'h00;
         exp_out   <= 16'h0000;
         exp_ps    <= 1'b0;
      end else begin
         k <= k + 1;
         if (k % PERIOD == 0) begin
            m_duty_sh <= duty;
         end
         exp_out <= model_out(k, (k % PERIOD == 0) ? duty : m_duty_sh,
                              {eo_hi, eo_lo}, {ep_hi, ep_lo});
         exp_ps  <= (k % PERIOD == 0);
      end
   end

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("out", 32'(out), 32'(exp_out));
         check("period_start", 32'(period_start), 32'(exp_ps));
      end
   end

   // ---------------- helpers ----------------
   // Waits (bounded) for a sampled period_start pulse; n = negedges waited.
   task automatic wait_ps(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_start !== 1'b1 && n < PERIOD + 100);
      check({tag, "_seen"}, 32'(period_start), 32'd1);
   endtask

   // Called on the negedge where period_start is high; walks one full period,
   // counting out[0] high cycles. Optionally writes a new duty mid-period.
   task automatic measure_period(input int change_at, input logic [7:0] new_duty,
                                 output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         if (len == change_at) begin
            duty = new_duty;
         end
         if (out[0] === 1'b1) begin
            hi++;
         end
         len++;
         @(negedge clk);
      end while (period_start !== 1'b1 && len < PERIOD + 100);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int hi;
      int len;
      int d;

      // Reset held with all inputs at 0xFF.
      {eo_hi, eo_lo} = 16'hFFFF;
      {ep_hi, ep_lo} = 16'hFFFF;
      duty           = 8'hFF;
      chk_en         = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_out", 32'(out), 32'h0);
      check("rst_ps", 32'(period_start), 32'h0);

      rst_n = 1'b1;
      wait_ps("first_ps", n);
      check("first_ps_edges", n, 1);
      wait_ps("second_ps", n);
      check("ps_interval", n, PERIOD);

      // Static modes.
      {eo_hi, eo_lo} = 16'hA5A5;
      {ep_hi, ep_lo} = 16'h0000;
      @(negedge clk);
      check("static_a5a5", 32'(out), 32'hA5A5);
      {eo_hi, eo_lo} = 16'h0000;
      @(negedge clk);
      check("static_off", 32'(out), 32'h0);

      // 50 % on output 0.
      {eo_hi, eo_lo} = 16'h0001;
      {ep_hi, ep_lo} = 16'h0001;
      duty           = 8'h80;
      wait_ps("pwm50_sync", n);
      repeat (2) begin
         measure_period(-1, 8'h00, hi, len);
         check("pwm50_hi", hi, 128 * P);
         check("pwm50_len", len, PERIOD);
         check("pwm50_upper", 32'(out[15:1]), 32'h0);
      end

      // Extremes.
      duty = 8'h00;
      wait_ps("duty00_sync", n);
      repeat (2) begin
         measure_period(-1, 8'h00, hi, len);
         check("duty00_hi", hi, 0);
      end
      duty = 8'hFF;
      wait_ps("dutyff_sync", n);
      repeat (2) begin
         measure_period(-1, 8'h00, hi, len);
         check("dutyff_hi", hi, PERIOD);
      end

      // Shadowing: 0x40 -> 0xC0 written mid-period.
      duty = 8'h40;
      wait_ps("shadow_sync", n);
      measure_period(1000, 8'hC0, hi, len);
      check("shadow_cur_hi", hi, 64 * P);
      check("shadow_next_start", 32'(out[0]), 32'd1);
      measure_period(-1, 8'h00, hi, len);
      check("shadow_next_hi", hi, 192 * P);

      // Random duty in 1..254.
      d    = $urandom_range(1, 254);
      duty = 8'(d);
      wait_ps("rand_duty_sync", n);
      measure_period(-1, 8'h00, hi, len);
      check("rand_duty_hi", hi, d * P);

      // Asynchronous reset mid-period.
      {eo_hi, eo_lo} = 16'hFFFF;
      {ep_hi, ep_lo} = 16'h0000;
      repeat (500) @(negedge clk);
      check("pre_reset_out", 32'(out), 32'hFFFF);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_out", 32'(out), 32'h0);
      check("async_ps", 32'(period_start), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_ps("post_rst_first", n);
      check("post_rst_first_edges", n, 1);
      wait_ps("post_rst_second", n);
      check("post_rst_interval", n, PERIOD);

      // Random enables and duty writes at arbitrary times; the per-cycle
      // model comparison covers these.
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 3) begin
            {eo_hi, eo_lo} = 16'($urandom);
            {ep_hi, ep_lo} = 16'($urandom);
         end
         if ($urandom_range(0, 199) < 3) begin
            duty = 8'($urandom);
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pwm_output_ctrl
